// File: rtl/unary_bar_counter_pkg.sv
// Shared types and elaboration helpers for the unary bar counter.
// Sizes the count and repeat-timer registers from the parameters.
package unary_bar_counter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLD_UP = 2'd1,
        HOLD_DN = 2'd2
    } state_e;

    // Number of bits needed to index v distinct values (0 for v <= 1).
    function automatic int clog2(input int v);
        int r;
        int p;
        r = 0;
        p = 1;
        while (p < v) begin
            p = p << 1;
            r = r + 1;
        end
        return r;
    endfunction

    // The timer must hold values up to the larger of the two reload targets.
    function automatic int timer_width(input int hold_cyc, input int repeat_cyc);
        int m;
        int w;
        m = (hold_cyc > repeat_cyc) ? hold_cyc : repeat_cyc;
        w = clog2(m + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/unary_bar_counter_therm_dcdr.sv
// Combinational count-to-thermometer decoder: bit i is lit when count > i.
module therm_dcdr
    import unary_bar_counter_pkg::*;
#(
    parameter int N = 15,
    localparam int W = clog2(N + 1)
) (
    input  logic [W-1:0] count_i,
    output logic [N-1:0] therm_o
);

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_bit
            assign therm_o[gi] = (count_i > W'(gi));
        end
    endgenerate

endmodule

// File: rtl/unary_bar_counter.sv
// Two-button up/down counter with a thermometer LED bar, optional wrap,
// hold-to-auto-repeat, and idle-time bar inversion driven by the raw buttons.
module unary_bar_counter
    import unary_bar_counter_pkg::*;
#(
    parameter int N          = 15,
    parameter int WRAP       = 0,
    parameter int INV_IDLE   = 1,
    parameter int HOLD_CYC   = 0,
    parameter int REPEAT_CYC = 1,
    localparam int W         = clog2(N + 1)
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         BTN_UP,
    input  logic         BTN_DN,
    output logic [W-1:0] COUNT,
    output logic [N-1:0] LED,
    output logic         AT_MAX,
    output logic         AT_MIN
);

    localparam int TW = timer_width(HOLD_CYC, REPEAT_CYC);
    localparam logic [W-1:0]  N_W      = W'(N);
    localparam logic [TW-1:0] HOLD_T   = TW'(HOLD_CYC);
    localparam logic [TW-1:0] REPEAT_T = TW'(REPEAT_CYC);

    generate
        if (N < 1) begin : g_bad_n
            $error("unary_bar_counter: N must be at least 1");
        end
        if (HOLD_CYC > 0 && REPEAT_CYC < 1) begin : g_bad_repeat
            $error("unary_bar_counter: REPEAT_CYC must be at least 1 when auto-repeat is enabled");
        end
    endgenerate

    state_e        state_q, state_d;
    logic [W-1:0]  count_q, count_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [TW-1:0] tmr_inc;
    logic          rpt_q, rpt_d;
    logic          at_max_q, at_max_d;
    logic          at_min_q, at_min_d;
    logic          step_up, step_dn;
    logic [N-1:0]  therm;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        tmr_d    = tmr_q;
        rpt_d    = rpt_q;
        step_up  = 1'b0;
        step_dn  = 1'b0;
        tmr_inc  = tmr_q + TW'(1);

        if (BTN_UP && BTN_DN) begin
            state_d = IDLE;
            tmr_d   = '0;
        end else if (!BTN_UP && !BTN_DN) begin
            state_d = IDLE;
        end else if (BTN_UP && state_q != HOLD_UP) begin
            step_up = 1'b1;
            state_d = HOLD_UP;
            tmr_d   = '0;
            rpt_d   = 1'b0;
        end else if (BTN_DN && state_q != HOLD_DN) begin
            step_dn = 1'b1;
            state_d = HOLD_DN;
            tmr_d   = '0;
            rpt_d   = 1'b0;
        end else if (HOLD_CYC != 0) begin
            // Same button still held: first repeat waits HOLD_CYC, later ones REPEAT_CYC.
            if (tmr_inc == (rpt_q ? REPEAT_T : HOLD_T)) begin
                step_up = BTN_UP;
                step_dn = BTN_DN;
                tmr_d   = '0;
                rpt_d   = 1'b1;
            end else begin
                tmr_d = tmr_inc;
            end
        end

        if (step_up) begin
            count_d = (count_q == N_W) ? ((WRAP != 0) ? '0 : N_W) : count_q + W'(1);
        end else if (step_dn) begin
            count_d = (count_q == '0) ? ((WRAP != 0) ? N_W : '0) : count_q - W'(1);
        end

        at_max_d = (count_d == N_W);
        at_min_d = (count_d == '0);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= IDLE;
            count_q  <= '0;
            tmr_q    <= '0;
            rpt_q    <= 1'b0;
            at_max_q <= 1'b0;
            at_min_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            tmr_q    <= tmr_d;
            rpt_q    <= rpt_d;
            at_max_q <= at_max_d;
            at_min_q <= at_min_d;
        end
    end

    therm_dcdr #(.N(N)) u_therm (
        .count_i (count_q),
        .therm_o (therm)
    );

    // Inversion tracks the raw buttons, so the bar flips without waiting for a clock edge.
    always_comb begin
        LED = therm;
        if (INV_IDLE != 0 && !(BTN_UP || BTN_DN)) begin
            LED = ~therm;
        end
    end

    assign COUNT  = count_q;
    assign AT_MAX = at_max_q;
    assign AT_MIN = at_min_q;

endmodule
